// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter
// Sequences the single-ported unified instruction/data memory of the pipe_MIPS32 core.
// Three requesters share it with fixed priority LD > D > I. A starvation counter
// lets instruction fetch win once it has lost STARVE_LIMIT arbitrations in a row.
//
// Ports
//   c1, rst_n                 clock (rising edge), async active-low reset
//   halted                    core halted; masks i_req
//   ld_req/we/addr/wdata      loader/debug request;  ld_gnt, ld_done pulses
//   d_req/we/addr/wdata       MEM-stage request;     d_gnt,  d_done  pulses
//   i_req/addr                fetch request (read);  i_gnt,  i_done  pulses
//   rdata                     read data, valid with the matching *_done
//   mem_en/we/addr/wdata      memory strobe and access attributes
//   mem_rdata                 memory data, valid MEM_LAT cycles after mem_en
//   busy                      arbiter not idle
module mips_mem_arbiter #(
    parameter int unsigned AW           = 10,
    parameter int unsigned DW           = 32,
    parameter int unsigned MEM_LAT      = 1,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic          c1,
    input  logic          rst_n,
    input  logic          halted,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_done,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_done,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;
    typedef enum logic [1:0] {SrcNone, SrcLd, SrcD, SrcI} src_e;

    localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);
    localparam logic [2:0] WaitLast  = 3'(MEM_LAT - 1);

    state_e        r_state, w_state_nxt;
    src_e          r_src, w_win;
    logic [3:0]    r_scnt, w_scnt_nxt;
    logic [2:0]    r_wcnt, w_wcnt_nxt;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_rdata;
    logic          w_arb;
    logic          w_i_elig;
    logic          w_last_wait;

    assign w_arb       = (r_state == StIdle) || (r_state == StDone);
    assign w_i_elig    = i_req & ~halted;
    assign w_last_wait = (r_state == StWait) && (r_wcnt == 3'd0);

    // Starvation override first, then fixed priority.
    always_comb begin
        w_win = SrcNone;
        if (w_i_elig && (r_scnt == StarveLim)) begin
            w_win = SrcI;
        end else if (ld_req) begin
            w_win = SrcLd;
        end else if (d_req) begin
            w_win = SrcD;
        end else if (w_i_elig) begin
            w_win = SrcI;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_scnt_nxt  = r_scnt;
        w_wcnt_nxt  = r_wcnt;
        ld_gnt      = 1'b0;
        d_gnt       = 1'b0;
        i_gnt       = 1'b0;
        ld_done     = 1'b0;
        d_done      = 1'b0;
        i_done      = 1'b0;
        mem_en      = 1'b0;
        unique case (r_state)
            StIdle, StDone: begin
                if (r_state == StDone) begin
                    ld_done = (r_src == SrcLd);
                    d_done  = (r_src == SrcD);
                    i_done  = (r_src == SrcI);
                end
                w_state_nxt = (w_win != SrcNone) ? StAccess : StIdle;
                if (!w_i_elig || (w_win == SrcI)) begin
                    w_scnt_nxt = 4'd0;
                end else if (r_scnt != 4'hF) begin
                    w_scnt_nxt = r_scnt + 4'd1;
                end
            end
            StAccess: begin
                mem_en      = 1'b1;
                ld_gnt      = (r_src == SrcLd);
                d_gnt       = (r_src == SrcD);
                i_gnt       = (r_src == SrcI);
                w_state_nxt = StWait;
                w_wcnt_nxt  = WaitLast;
            end
            StWait: begin
                if (r_wcnt == 3'd0) begin
                    w_state_nxt = StDone;
                end else begin
                    w_wcnt_nxt = r_wcnt - 3'd1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge c1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_scnt  <= 4'd0;
            r_wcnt  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_scnt  <= w_scnt_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    // Access attributes are captured at the arbitration edge and then held until the
    // next win, so mem_* keep their last values between accesses.
    always_ff @(posedge c1 or negedge rst_n) begin
        if (!rst_n) begin
            r_src       <= SrcNone;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            if (w_arb && (w_win != SrcNone)) begin
                r_src <= w_win;
                unique case (w_win)
                    SrcLd: begin
                        r_mem_we    <= ld_we;
                        r_mem_addr  <= ld_addr;
                        r_mem_wdata <= ld_wdata;
                    end
                    SrcD: begin
                        r_mem_we    <= d_we;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                    end
                    SrcI: begin
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= i_addr;
                    end
                    default: ;
                endcase
            end
            if (w_last_wait) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    assign rdata     = r_rdata;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: directed scenarios plus randomized requesters, all checked
// cycle by cycle against a transaction-level reference model of the arbiter.
module tb_mips_mem_arbiter;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int LAT  = 1;
    localparam int SLIM = 3;
    localparam int NCYC = 4000;

    logic          c1    = 1'b0;
    logic          rst_n = 1'b0;
    logic          halted = 1'b0;
    logic [2:0]    req   = '0;
    logic [2:0]    we    = '0;
    logic [AW-1:0] addr  [3];
    logic [DW-1:0] wdata [3];

    logic          ld_gnt, ld_done, d_gnt, d_done, i_gnt, i_done;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [2:0]    gnt_v, done_v;

    assign gnt_v  = {i_gnt, d_gnt, ld_gnt};
    assign done_v = {i_done, d_done, ld_done};

    mips_mem_arbiter #(
        .AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_LIMIT(SLIM)
    ) u_dut (
        .c1(c1), .rst_n(rst_n), .halted(halted),
        .ld_req(req[0]), .ld_we(we[0]), .ld_addr(addr[0]), .ld_wdata(wdata[0]),
        .ld_gnt(ld_gnt), .ld_done(ld_done),
        .d_req(req[1]), .d_we(we[1]), .d_addr(addr[1]), .d_wdata(wdata[1]),
        .d_gnt(d_gnt), .d_done(d_done),
        .i_req(req[2]), .i_addr(addr[2]), .i_gnt(i_gnt), .i_done(i_done),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 c1 = ~c1;

    // Behavioural memory device with LAT-cycle read latency.
    bit   [DW-1:0] dev_mem [1024];
    bit            dev_wr  [1024];
    logic [DW-1:0] rd_pipe [LAT];

    function automatic logic [DW-1:0] init_word(input int a);
        if (a == 0) return 32'h28010078;
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [DW-1:0] dev_read(input logic [AW-1:0] a);
        return dev_wr[a] ? dev_mem[a] : init_word(int'(a));
    endfunction

    always @(posedge c1) begin
        if (mem_en) begin
            rd_pipe[0] <= dev_read(mem_addr);
            if (mem_we) begin
                dev_mem[mem_addr] <= mem_wdata;
                dev_wr[mem_addr]  <= 1'b1;
            end
        end
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    // Reference model state and per-cycle expectations.
    logic [DW-1:0] mdl_mem   [1024];
    logic [2:0]    exp_gnt   [NCYC];
    logic [2:0]    exp_done  [NCYC];
    logic          exp_busy  [NCYC];
    logic          exp_rchk  [NCYC];
    logic [DW-1:0] exp_rdata [NCYC];
    logic          exp_we    [NCYC];
    logic [AW-1:0] exp_addr  [NCYC];
    logic [DW-1:0] exp_wdata [NCYC];
    int            cyc, free_at, scnt;
    logic [2:0]    granted, saw_gnt, hold;
    bit            rand_en;
    int            n_chk, n_pass;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, gnt_v, 3'b000);
        chk({tag, "_done"}, done_v, 3'b000);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_mem_en"}, mem_en, 1'b0);
        chk({tag, "_mem_we"}, mem_we, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, '0);
        chk({tag, "_mem_wdata"}, mem_wdata, '0);
        chk({tag, "_rdata"}, rdata, '0);
    endtask

    task automatic clear_exp(input int from);
        for (int t = from; t < NCYC; t++) begin
            exp_gnt[t] = '0; exp_done[t] = '0; exp_busy[t] = 1'b0; exp_rchk[t] = 1'b0;
            exp_rdata[t] = '0; exp_we[t] = 1'b0; exp_addr[t] = '0; exp_wdata[t] = '0;
        end
    endtask

    // One arbitration decision, taken from the inputs of the current cycle.
    task automatic model_arb();
        bit ielig;
        int win, d;
        if (cyc < free_at) return;
        ielig = req[2] && !halted;
        win = -1;
        if (ielig && scnt == SLIM) win = 2;
        else if (req[0]) win = 0;
        else if (req[1]) win = 1;
        else if (ielig) win = 2;
        if (!ielig || win == 2) scnt = 0;
        else scnt++;
        if (win < 0) return;
        d = cyc + 2 + LAT;
        granted[win] = 1'b1;
        exp_gnt[cyc+1]   = 3'b001 << win;
        exp_addr[cyc+1]  = addr[win];
        exp_we[cyc+1]    = (win == 2) ? 1'b0 : we[win];
        exp_wdata[cyc+1] = wdata[win];
        for (int t = cyc + 1; t <= d; t++) exp_busy[t] = 1'b1;
        exp_done[d] = 3'b001 << win;
        if (exp_we[cyc+1]) begin
            mdl_mem[addr[win]] = wdata[win];
        end else begin
            exp_rchk[d]  = 1'b1;
            exp_rdata[d] = mdl_mem[addr[win]];
        end
        free_at = d;
    endtask

    task automatic compare_cycle();
        chk("gnt", gnt_v, exp_gnt[cyc]);
        chk("done", done_v, exp_done[cyc]);
        chk("busy", busy, exp_busy[cyc]);
        chk("mem_en", mem_en, exp_gnt[cyc] != 3'b000);
        if (exp_gnt[cyc] != 3'b000) begin
            chk("mem_addr", mem_addr, exp_addr[cyc]);
            chk("mem_we", mem_we, exp_we[cyc]);
            if (exp_we[cyc]) chk("mem_wdata", mem_wdata, exp_wdata[cyc]);
        end
        if (exp_rchk[cyc]) chk("rdata", rdata, exp_rdata[cyc]);
        saw_gnt = gnt_v;
        granted = granted & ~gnt_v;
    endtask

    task automatic drive_agents();
        for (int k = 0; k < 3; k++) begin
            if (req[k] && saw_gnt[k] && !hold[k]) begin
                req[k] = 1'b0;
            end else if (rand_en && !req[k] && $urandom_range(0, 99) < 30) begin
                req[k]   = 1'b1;
                we[k]    = (k == 2) ? 1'b0 : 1'($urandom_range(0, 1));
                addr[k]  = AW'($urandom_range(0, 15));
                wdata[k] = $urandom;
            end else if (rand_en && req[k] && !granted[k] && $urandom_range(0, 99) < 4) begin
                req[k] = 1'b0;
            end
        end
        if (rand_en && $urandom_range(0, 99) < 5) halted = ~halted;
    endtask

    task automatic begin_cycle();
        @(posedge c1);
        #1;
        drive_agents();
    endtask

    task automatic finish_cycle();
        @(negedge c1);
        if (cyc >= NCYC - 8) begin
            $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, NCYC - 8);
            $fatal(1);
        end
        compare_cycle();
        model_arb();
        cyc++;
    endtask

    task automatic step();
        begin_cycle();
        finish_cycle();
    endtask

    task automatic quiesce();
        rand_en = 1'b0;
        hold    = '0;
        begin_cycle();
        halted = 1'b0;
        finish_cycle();
        for (int i = 0; i < 40; i++) begin
            step();
            if (req == 3'b000 && !busy) return;
        end
        chk("quiesce_timeout", {req, busy}, 4'b0000);
    endtask

    task automatic wait_done(input int k, input int maxc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (done_v[k]) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit         seen;
        int         g_at [3];
        int         nbusy, n, nld, ni;
        logic [2:0] gs [5];

        n_chk = 0; n_pass = 0;
        for (int a = 0; a < 1024; a++) mdl_mem[a] = init_word(a);
        for (int k = 0; k < 3; k++) begin addr[k] = '0; wdata[k] = '0; end
        clear_exp(0);
        granted = '0; saw_gnt = '0; hold = '0; rand_en = 1'b0;
        cyc = 0; free_at = 0; scnt = 0;

        #12;
        chk_all_zero("reset");
        @(negedge c1);
        rst_n = 1'b1;

        // Fetch of address 0: gnt one cycle later, done three cycles later.
        quiesce();
        begin_cycle(); req[2] = 1'b1; addr[2] = 10'd0; finish_cycle();
        step();
        chk("a_i_gnt", i_gnt, 1'b1);
        chk("a_mem_en", mem_en, 1'b1);
        step(); step();
        chk("a_i_done", i_done, 1'b1);
        chk("a_rdata", rdata, 32'h28010078);

        // Loader write followed by a data read of the same word.
        quiesce();
        begin_cycle();
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 10'd120; wdata[0] = 32'd85;
        finish_cycle();
        wait_done(0, 10, seen);
        chk("b_ld_done_seen", seen, 1'b1);
        chk("b_mem120", dev_read(10'd120), 32'd85);
        quiesce();
        begin_cycle(); req[1] = 1'b1; we[1] = 1'b0; addr[1] = 10'd120; finish_cycle();
        wait_done(1, 10, seen);
        chk("b_d_done_seen", seen, 1'b1);
        chk("b_rdata", rdata, 32'd85);

        // All three requesters at once.
        quiesce();
        begin_cycle();
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b1; we[k] = 1'b0; addr[k] = AW'(k + 1);
        end
        finish_cycle();
        g_at = '{-1, -1, -1};
        nbusy = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (busy) nbusy++;
            for (int k = 0; k < 3; k++) if (gnt_v[k] && g_at[k] < 0) g_at[k] = i;
        end
        chk("c_ld_first", g_at[0], 0);
        chk("c_d_gap", g_at[1] - g_at[0], 3);
        chk("c_i_gap", g_at[2] - g_at[1], 3);
        chk("c_busy_len", nbusy, 9);

        // D and I held continuously: I is starved for exactly SLIM arbitrations.
        quiesce();
        hold = 3'b110;
        begin_cycle();
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 10'd5; req[2] = 1'b1; addr[2] = 10'd6;
        finish_cycle();
        gs = '{default: 3'b000};
        n = 0;
        for (int i = 0; i < 30 && n < 5; i++) begin
            step();
            if (gnt_v != 3'b000) begin gs[n] = gnt_v; n++; end
        end
        hold = '0;
        chk("d_g0", gs[0], 3'b010);
        chk("d_g1", gs[1], 3'b010);
        chk("d_g2", gs[2], 3'b010);
        chk("d_g3", gs[3], 3'b100);
        chk("d_g4", gs[4], 3'b010);

        // Halted core: fetch ignored until halted drops.
        quiesce();
        hold = 3'b101;
        begin_cycle();
        halted = 1'b1;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 10'd7; req[2] = 1'b1; addr[2] = 10'd8;
        finish_cycle();
        nld = 0; ni = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (ld_gnt) nld++;
            if (i_gnt) ni++;
        end
        chk("e_no_i_gnt", ni, 0);
        chk("e_ld_gnts", nld, 4);
        hold[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (req[0] == 1'b0 && !busy) break;
        end
        begin_cycle(); halted = 1'b0; finish_cycle();
        step();
        chk("e_i_gnt_next", i_gnt, 1'b1);

        // Reset in the middle of a fetch.
        quiesce();
        begin_cycle(); req[2] = 1'b1; addr[2] = 10'd0; finish_cycle();
        step();
        begin_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("f_async");
        for (int i = 0; i < 2; i++) begin
            @(negedge c1);
            chk("f_no_done_in_rst", done_v, 3'b000);
        end
        req = '0;
        rst_n = 1'b1;
        cyc++;
        clear_exp(cyc);
        free_at = cyc; scnt = 0; granted = '0; saw_gnt = '0;
        for (int i = 0; i < 4; i++) step();
        begin_cycle(); req[2] = 1'b1; addr[2] = 10'd0; finish_cycle();
        step(); step(); step();
        chk("f_i_done", i_done, 1'b1);
        chk("f_rdata", rdata, 32'h28010078);

        // Randomized traffic against the model.
        quiesce();
        rand_en = 1'b1;
        for (int i = 0; i < 2500; i++) step();
        quiesce();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
